// File: rtl/nios_system_tile_dispatcher_if.sv
// nios_system_tile_dispatcher_if
// Bus bundle for the tile dispatcher: the host control slave, the per-core
// Avalon-MM slaves and the job-complete interrupt.
//   ctl_address/ctl_read/ctl_write/ctl_writedata : host control slave inputs
//   ctl_readdata                                 : host read data (zero-wait)
//   core_address (2 bits per core), core_read, core_write : per-core requests
//   core_readdata (32 bits per core), core_waitrequest    : per-core responses
//   irq                                          : level job-complete interrupt
// The "slave" modport is the dispatcher's view; "master" is the view of the
// host plus cores driving it.
interface nios_system_tile_dispatcher_if #(
  parameter int NUM_CORES = 4
);
  logic [2:0]              ctl_address;
  logic                    ctl_read;
  logic                    ctl_write;
  logic [31:0]             ctl_writedata;
  logic [31:0]             ctl_readdata;
  logic [2*NUM_CORES-1:0]  core_address;
  logic [NUM_CORES-1:0]    core_read;
  logic [NUM_CORES-1:0]    core_write;
  logic [32*NUM_CORES-1:0] core_readdata;
  logic [NUM_CORES-1:0]    core_waitrequest;
  logic                    irq;

  modport master (
    output ctl_address, ctl_read, ctl_write, ctl_writedata,
    output core_address, core_read, core_write,
    input  ctl_readdata, core_readdata, core_waitrequest, irq
  );

  modport slave (
    input  ctl_address, ctl_read, ctl_write, ctl_writedata,
    input  core_address, core_read, core_write,
    output ctl_readdata, core_readdata, core_waitrequest, irq
  );
endinterface

// File: rtl/nios_system_tile_dispatcher.sv
// nios_system_tile_dispatcher
// Hands out image-tile indices to NUM_CORES cores with round-robin
// arbitration, counts tile completions and raises irq when a job finishes.
// Each core slave also serves the group identification word.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : nios_system_tile_dispatcher_if.slave (host control slave,
//             per-core slaves, irq)
// Host map: 0 status {state, done, busy}, 1 next, 2 done_cnt, 3 total,
//           4..7 per-core grant counters (0 unless stats are built).
// Core map: read 0 fetch, read 1 GROUP_ID, read 2/3 zero, write 2 completion.
// Optional feature: define DISPATCH_STATS_EN to build 32-bit grant counters
// for cores 0..min(NUM_CORES,4)-1.
module nios_system_tile_dispatcher #(
  parameter int          NUM_CORES = 4,
  parameter int          TILE_W    = 16,
  parameter logic [31:0] GROUP_ID  = 32'd1537299572
) (
  input logic                          clock,
  input logic                          reset_n,
  nios_system_tile_dispatcher_if.slave bus
);

  localparam int RR_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [TILE_W-1:0] total, total_nxt;
  logic [TILE_W-1:0] next_idx, next_nxt;
  logic [TILE_W-1:0] done_cnt, done_nxt;
  logic [RR_W-1:0]   rr, rr_nxt;
  logic              irq_q, irq_nxt;

  logic [NUM_CORES-1:0]    fetch_req;
  logic [NUM_CORES-1:0]    comp_req;
  logic [NUM_CORES-1:0]    core_wait;
  logic [32*NUM_CORES-1:0] core_rdata;
  logic                    grant_valid;
  logic [RR_W-1:0]         grant_idx;
  logic [RR_W:0]           cand_sum;
  logic [RR_W-1:0]         cand;
  logic [3:0]              comp_cnt;
  logic [TILE_W:0]         done_sum;
  logic                    job_start;
  logic                    job_ack;
  logic [31:0]             stats_rdata;
  logic [31:0]             ctl_rdata;

  // Decode per-core requests into fetches (read addr 0) and completions
  // (write addr 2), and count how many completions arrive this cycle.
  always_comb begin
    fetch_req = '0;
    comp_req  = '0;
    comp_cnt  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      fetch_req[k] = bus.core_read[k]  && (bus.core_address[2*k +: 2] == 2'd0);
      comp_req[k]  = bus.core_write[k] && (bus.core_address[2*k +: 2] == 2'd2);
      if (comp_req[k]) comp_cnt = comp_cnt + 4'd1;
    end
  end

  // Round-robin search: first fetching core at or after rr, with wrap.
  // Only RUN grants; other states answer every fetch with "no work".
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    if (state == RUN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cand_sum = {1'b0, rr} + (RR_W+1)'(i);
        if (cand_sum >= (RR_W+1)'(NUM_CORES))
          cand_sum = cand_sum - (RR_W+1)'(NUM_CORES);
        cand = cand_sum[RR_W-1:0];
        if (!grant_valid && fetch_req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Per-core responses; only a losing RUN fetch ever waits.
  always_comb begin
    core_wait  = '0;
    core_rdata = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (bus.core_read[k]) begin
        case (bus.core_address[2*k +: 2])
          2'd0: begin
            if (state == RUN) begin
              if (grant_valid && (grant_idx == RR_W'(k)))
                core_rdata[32*k +: 32] = 32'(next_idx);
              else
                core_wait[k] = 1'b1;
            end else begin
              core_rdata[32*k +: 32] = 32'hFFFF_FFFF;
            end
          end
          2'd1:    core_rdata[32*k +: 32] = GROUP_ID;
          default: core_rdata[32*k +: 32] = 32'd0;
        endcase
      end
    end
  end

  assign job_start = (state == IDLE) && bus.ctl_write && (bus.ctl_address == 3'd0) &&
                     (bus.ctl_writedata[TILE_W-1:0] != '0);
  assign job_ack   = (state == DONE) && bus.ctl_write && (bus.ctl_address == 3'd3);

  // Next-state and register update logic. Fetch and completion are
  // independent and both take effect on the same edge.
  always_comb begin
    state_nxt = state;
    total_nxt = total;
    next_nxt  = next_idx;
    done_nxt  = done_cnt;
    rr_nxt    = rr;
    irq_nxt   = irq_q;
    done_sum  = {1'b0, done_cnt} + (TILE_W+1)'(comp_cnt);
    case (state)
      IDLE: begin
        if (job_start) begin
          total_nxt = bus.ctl_writedata[TILE_W-1:0];
          next_nxt  = '0;
          done_nxt  = '0;
          state_nxt = RUN;
        end
      end
      RUN, DRAIN: begin
        if (grant_valid) begin
          next_nxt = next_idx + 1'b1;
          rr_nxt   = (grant_idx == RR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
          if (next_idx + 1'b1 == total) state_nxt = DRAIN;
        end
        // Completion count saturates at total.
        if (done_sum >= {1'b0, total}) done_nxt = total;
        else                           done_nxt = done_sum[TILE_W-1:0];
        // Reaching total in RUN only saturates; the job finishes from DRAIN.
        if ((state == DRAIN) && (done_nxt == total)) begin
          state_nxt = DONE;
          irq_nxt   = 1'b1;
        end
      end
      DONE: begin
        if (job_ack) begin
          state_nxt = IDLE;
          irq_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      total    <= '0;
      next_idx <= '0;
      done_cnt <= '0;
      rr       <= '0;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      total    <= total_nxt;
      next_idx <= next_nxt;
      done_cnt <= done_nxt;
      rr       <= rr_nxt;
      irq_q    <= irq_nxt;
    end
  end

`ifdef DISPATCH_STATS_EN
  localparam int NUM_STATS = (NUM_CORES < 4) ? NUM_CORES : 4;

  logic [31:0] grant_cnt [NUM_STATS];

  // Grant counters clear on reset and on each job start, and wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset_n || job_start) begin
      for (int k = 0; k < NUM_STATS; k++) grant_cnt[k] <= '0;
    end else if (grant_valid) begin
      for (int k = 0; k < NUM_STATS; k++)
        if (grant_idx == RR_W'(k)) grant_cnt[k] <= grant_cnt[k] + 32'd1;
    end
  end

  always_comb begin
    stats_rdata = '0;
    for (int k = 0; k < NUM_STATS; k++)
      if (bus.ctl_address[1:0] == 2'(k)) stats_rdata = grant_cnt[k];
  end
`else
  assign stats_rdata = '0;
`endif

  always_comb begin
    ctl_rdata = '0;
    if (bus.ctl_read) begin
      case (bus.ctl_address)
        3'd0:    ctl_rdata = {28'd0, 2'(state), (state == DONE),
                              (state == RUN) || (state == DRAIN)};
        3'd1:    ctl_rdata = 32'(next_idx);
        3'd2:    ctl_rdata = 32'(done_cnt);
        3'd3:    ctl_rdata = 32'(total);
        default: ctl_rdata = stats_rdata;
      endcase
    end
  end

  assign bus.ctl_readdata     = ctl_rdata;
  assign bus.core_readdata    = core_rdata;
  assign bus.core_waitrequest = core_wait;
  assign bus.irq              = irq_q;

endmodule
